// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU encodings, RV32I opcodes,
// funct3 values, immediate/operand selectors and the stage register layout.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef enum logic [1:0] {SEL_A_RS1, SEL_A_PC, SEL_A_ZERO} sel_a_e;
  typedef enum logic [1:0] {SEL_B_RS2, SEL_B_IMM, SEL_B_FOUR} sel_b_e;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    sel_a_e      sel_a;
    sel_b_e      sel_b;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
  } id_ex_t;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  // funct7[5] selects SUB only for register-register ops; ADDI ignores it
  function automatic logic [3:0] alu_op_of(input logic [2:0] funct3,
                                           input logic funct7_b5,
                                           input logic is_op_imm);
    case (funct3)
      F3_ADD_SUB: return (funct7_b5 && !is_op_imm) ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return funct7_b5 ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational RV32I immediate extraction; format chosen from the opcode,
// result sign-extended from instruction bit 31.
module id_ex_stage_imm_gen
  import id_ex_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (imm_type_of(instr_i[6:0]))
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: decodes ALU controls, forwards
// from EX/MEM and MEM/WB, and flags load-use hazards back to decode.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            Clk_i,
  input  logic            Rst_i,
  input  logic            Valid_i,
  input  logic [31:0]     Instr_i,
  input  logic [XLEN-1:0] Pc_i,
  input  logic [XLEN-1:0] Rs1Data_i,
  input  logic [XLEN-1:0] Rs2Data_i,
  input  logic            Stall_i,
  input  logic            Flush_i,
  input  logic            ExMemRegWrite_i,
  input  logic [4:0]      ExMemRd_i,
  input  logic [XLEN-1:0] ExMemResult_i,
  input  logic            MemWbRegWrite_i,
  input  logic [4:0]      MemWbRd_i,
  input  logic [XLEN-1:0] MemWbResult_i,
  output logic [3:0]      AluOp_o,
  output logic [XLEN-1:0] AluInA_o,
  output logic [XLEN-1:0] AluInB_o,
  output logic [XLEN-1:0] StoreData_o,
  output logic            Valid_o,
  output logic            RegWrite_o,
  output logic            MemRead_o,
  output logic            MemWrite_o,
  output logic            Branch_o,
  output logic            Jump_o,
  output logic            Illegal_o,
  output logic [4:0]      Rd_o,
  output logic [2:0]      Funct3_o,
  output logic [XLEN-1:0] Pc_o,
  output logic            LoadUseHazard_o
);

  id_ex_t    stage_q, stage_d;
  logic [31:0] imm_raw;
  logic [31:0] rs1_fwd, rs2_fwd;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  assign opcode = Instr_i[6:0];
  assign funct3 = Instr_i[14:12];

  id_ex_stage_imm_gen u_imm_gen (
    .instr_i (Instr_i),
    .imm_o   (imm_raw)
  );

  always_comb begin
    rs1_fwd = stage_q.rs1_data;
    if (ExMemRegWrite_i && (ExMemRd_i != 5'd0) && (ExMemRd_i == stage_q.rs1))
      rs1_fwd = ExMemResult_i;
    else if (MemWbRegWrite_i && (MemWbRd_i != 5'd0) && (MemWbRd_i == stage_q.rs1))
      rs1_fwd = MemWbResult_i;

    rs2_fwd = stage_q.rs2_data;
    if (ExMemRegWrite_i && (ExMemRd_i != 5'd0) && (ExMemRd_i == stage_q.rs2))
      rs2_fwd = ExMemResult_i;
    else if (MemWbRegWrite_i && (MemWbRd_i != 5'd0) && (MemWbRd_i == stage_q.rs2))
      rs2_fwd = MemWbResult_i;
  end

  always_comb begin
    stage_d = stage_q;
    if (Flush_i) begin
      stage_d.valid     = 1'b0;
      stage_d.reg_write = 1'b0;
      stage_d.mem_read  = 1'b0;
      stage_d.mem_write = 1'b0;
      stage_d.branch    = 1'b0;
      stage_d.jump      = 1'b0;
      stage_d.illegal   = 1'b0;
    end else if (Stall_i) begin
      // capture forwarded operands so they outlive the producer retiring
      stage_d.rs1_data = rs1_fwd;
      stage_d.rs2_data = rs2_fwd;
    end else begin
      stage_d.valid     = Valid_i;
      stage_d.alu_op    = ALU_ADD;
      stage_d.sel_a     = SEL_A_RS1;
      stage_d.sel_b     = SEL_B_RS2;
      stage_d.reg_write = 1'b0;
      stage_d.mem_read  = 1'b0;
      stage_d.mem_write = 1'b0;
      stage_d.branch    = 1'b0;
      stage_d.jump      = 1'b0;
      stage_d.illegal   = 1'b0;
      stage_d.rd        = Instr_i[11:7];
      stage_d.rs1       = Instr_i[19:15];
      stage_d.rs2       = Instr_i[24:20];
      stage_d.funct3    = funct3;
      stage_d.pc        = Pc_i;
      stage_d.rs1_data  = Rs1Data_i;
      stage_d.rs2_data  = Rs2Data_i;
      stage_d.imm       = imm_raw;
      case (opcode)
        OPC_OP: begin
          stage_d.alu_op    = alu_op_of(funct3, Instr_i[30], 1'b0);
          stage_d.reg_write = 1'b1;
        end
        OPC_OP_IMM: begin
          stage_d.alu_op    = alu_op_of(funct3, Instr_i[30], 1'b1);
          stage_d.sel_b     = SEL_B_IMM;
          stage_d.reg_write = 1'b1;
          // shift immediates carry funct7 in the upper bits; keep shamt only
          if ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA))
            stage_d.imm = {27'b0, imm_raw[4:0]};
        end
        OPC_LOAD: begin
          stage_d.sel_b     = SEL_B_IMM;
          stage_d.reg_write = 1'b1;
          stage_d.mem_read  = 1'b1;
        end
        OPC_STORE: begin
          stage_d.sel_b     = SEL_B_IMM;
          stage_d.mem_write = 1'b1;
        end
        OPC_LUI: begin
          stage_d.sel_a     = SEL_A_ZERO;
          stage_d.sel_b     = SEL_B_IMM;
          stage_d.reg_write = 1'b1;
        end
        OPC_AUIPC: begin
          stage_d.sel_a     = SEL_A_PC;
          stage_d.sel_b     = SEL_B_IMM;
          stage_d.reg_write = 1'b1;
        end
        OPC_JAL, OPC_JALR: begin
          stage_d.sel_a     = SEL_A_PC;
          stage_d.sel_b     = SEL_B_FOUR;
          stage_d.reg_write = 1'b1;
          stage_d.jump      = 1'b1;
        end
        OPC_BRANCH: begin
          stage_d.alu_op = ALU_SUB;
          stage_d.branch = 1'b1;
        end
        default: stage_d.illegal = 1'b1;
      endcase
      if (Instr_i[11:7] == 5'd0) stage_d.reg_write = 1'b0;
      if (!Valid_i) begin
        stage_d.reg_write = 1'b0;
        stage_d.mem_read  = 1'b0;
        stage_d.mem_write = 1'b0;
        stage_d.branch    = 1'b0;
        stage_d.jump      = 1'b0;
        stage_d.illegal   = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      stage_q        <= '0;
      stage_q.alu_op <= ALU_ADD;
      stage_q.sel_a  <= SEL_A_RS1;
      stage_q.sel_b  <= SEL_B_RS2;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    case (stage_q.sel_a)
      SEL_A_RS1: AluInA_o = rs1_fwd;
      SEL_A_PC:  AluInA_o = stage_q.pc;
      default:   AluInA_o = '0;
    endcase
    case (stage_q.sel_b)
      SEL_B_RS2: AluInB_o = rs2_fwd;
      SEL_B_IMM: AluInB_o = stage_q.imm;
      default:   AluInB_o = 32'd4;
    endcase
  end

  assign StoreData_o = rs2_fwd;
  assign AluOp_o     = stage_q.alu_op;
  assign Valid_o     = stage_q.valid;
  assign RegWrite_o  = stage_q.reg_write;
  assign MemRead_o   = stage_q.mem_read;
  assign MemWrite_o  = stage_q.mem_write;
  assign Branch_o    = stage_q.branch;
  assign Jump_o      = stage_q.jump;
  assign Illegal_o   = stage_q.illegal;
  assign Rd_o        = stage_q.rd;
  assign Funct3_o    = stage_q.funct3;
  assign Pc_o        = stage_q.pc;

  assign LoadUseHazard_o = stage_q.valid && stage_q.mem_read && (stage_q.rd != 5'd0) &&
                           Valid_i && ((stage_q.rd == Instr_i[19:15]) ||
                                       (stage_q.rd == Instr_i[24:20]));

endmodule
